// File: rtl/fp8_pkg.sv
// ---------------------------------------------------------------------------
// fp8_pkg
// Shared definitions for the 8-bit mini-float add/subtract sequencer.
// Word format: sign | EXP_W-bit exponent | FRAC_W-bit fraction, with an
// implied leading 1 on every value (there is no zero or denormal encoding).
// Provides the format widths, the sequencer state type, field extractors
// and the saturation / underflow magnitude constants.
// ---------------------------------------------------------------------------
package fp8_pkg;

   localparam int EXP_W  = 3;
   localparam int FRAC_W = 4;
   localparam int MANT_W = FRAC_W + 1;
   localparam int WORD_W = 1 + EXP_W + FRAC_W;

   // Both operands carry the same bias, so it cancels in the exponent
   // difference and never has to be applied inside the datapath.
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;

   // Alignment shifts beyond the mantissa width only ever produce zero,
   // so the shift counter is clamped to this value.
   localparam logic [EXP_W-1:0] SHIFT_CAP = EXP_W'(MANT_W);

   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [EXP_W-1:0] EXP_MIN = '0;

   // Magnitude fields (everything except the sign) for the special results.
   localparam logic [WORD_W-2:0] SAT_MAG  = '1;
   localparam logic [WORD_W-2:0] UNF_MAG  = '0;
   localparam logic [WORD_W-1:0] ZERO_WORD = '0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      ADD   = 3'd3,
      NORM  = 3'd4,
      DONE  = 3'd5
   } state_t;

   function automatic logic get_sign(input logic [WORD_W-1:0] w);
      return w[WORD_W-1];
   endfunction

   function automatic logic [EXP_W-1:0] get_exp(input logic [WORD_W-1:0] w);
      return w[WORD_W-2 -: EXP_W];
   endfunction

   function automatic logic [FRAC_W-1:0] get_frac(input logic [WORD_W-1:0] w);
      return w[FRAC_W-1:0];
   endfunction

endpackage

// File: rtl/fp8_mag_swap.sv
// ---------------------------------------------------------------------------
// fp8_mag_swap
// Purely combinational magnitude compare for two mini-float operands.
// Decides which operand is larger (exponent first, fraction on a tie),
// presents the larger one as "big" and the other as "small", flags exact
// magnitude equality and returns the exponent difference big - small.
//
// Ports:
//   a_exp, a_frac   in   exponent / fraction of operand A
//   b_exp, b_frac   in   exponent / fraction of operand B
//   swap            out  1 when B is strictly larger than A
//   mag_equal       out  1 when A and B have identical magnitude
//   big_exp         out  exponent of the larger operand
//   exp_diff        out  big exponent minus small exponent
//   big_mant        out  mantissa (implied 1 restored) of the larger operand
//   small_mant      out  mantissa (implied 1 restored) of the smaller operand
// ---------------------------------------------------------------------------
module fp8_mag_swap
   import fp8_pkg::*;
(
   input  logic [EXP_W-1:0]  a_exp,
   input  logic [FRAC_W-1:0] a_frac,
   input  logic [EXP_W-1:0]  b_exp,
   input  logic [FRAC_W-1:0] b_frac,
   output logic              swap,
   output logic              mag_equal,
   output logic [EXP_W-1:0]  big_exp,
   output logic [EXP_W-1:0]  exp_diff,
   output logic [MANT_W-1:0] big_mant,
   output logic [MANT_W-1:0] small_mant
);

   logic [EXP_W-1:0] small_exp;

   // Ordering is exponent-major, fraction-minor; because every value has
   // an implied leading 1 this is exactly a magnitude compare. On a tie A
   // stays "big", which keeps A's sign for equal-magnitude additions.
   always_comb begin
      swap       = (b_exp > a_exp) || ((b_exp == a_exp) && (b_frac > a_frac));
      mag_equal  = (b_exp == a_exp) && (b_frac == a_frac);
      big_exp    = swap ? b_exp : a_exp;
      small_exp  = swap ? a_exp : b_exp;
      big_mant   = swap ? {1'b1, b_frac} : {1'b1, a_frac};
      small_mant = swap ? {1'b1, a_frac} : {1'b1, b_frac};
      exp_diff   = big_exp - small_exp;
   end

endmodule

// File: rtl/fp8_addsub_seq.sv
// ---------------------------------------------------------------------------
// fp8_addsub_seq
// Multi-cycle add/subtract for the 8-bit mini-float format. One operand
// pair is captured in IDLE, then the sequencer walks SETUP (order the
// operands by magnitude), SHIFT (align the small mantissa one bit per
// cycle), ADD (6-bit add or subtract) and NORM (one normalising shift per
// cycle) before holding the packed result in DONE until it is taken.
// Rounding is plain truncation everywhere.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  high only in IDLE
//   op_a       in   operand A
//   op_b       in   operand B
//   mode       in   0 = A+B, 1 = A-B
//   out_valid  out  result valid, high only in DONE
//   out_ready  in   consumer accepts the result
//   result     out  packed result
//   zero       out  exact cancellation (result 0x00)
//   ovf        out  exponent overflow, result saturated
//   unf        out  exponent underflow, result is {sign, all zeros}
// ---------------------------------------------------------------------------
module fp8_addsub_seq
   import fp8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] op_a,
   input  logic [WORD_W-1:0] op_b,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] result,
   output logic              zero,
   output logic              ovf,
   output logic              unf
);

   state_t              state;

   logic [WORD_W-1:0]   a_r;
   logic [WORD_W-1:0]   b_r;
   logic                mode_r;

   logic                res_sign;
   logic                sub_r;
   logic [EXP_W-1:0]    exp_r;
   logic [MANT_W-1:0]   mant_big_r;
   logic [MANT_W-1:0]   mant_small_r;
   logic [EXP_W-1:0]    shift_cnt;
   logic [MANT_W:0]     sum_r;

   logic [WORD_W-1:0]   result_r;
   logic                zero_r;
   logic                ovf_r;
   logic                unf_r;

   logic                sign_a;
   logic                sign_b_eff;
   logic                eff_sub;
   logic [EXP_W-1:0]    shift_load;

   logic                swap;
   logic                mag_equal;
   logic [EXP_W-1:0]    big_exp;
   logic [EXP_W-1:0]    exp_diff;
   logic [MANT_W-1:0]   big_mant;
   logic [MANT_W-1:0]   small_mant;

   // The mode bit folds into B's sign, so a subtract is just an add of
   // operands whose effective signs differ. The alignment count is clamped
   // because anything past the mantissa width has already flushed to zero.
   always_comb begin
      sign_a     = get_sign(a_r);
      sign_b_eff = get_sign(b_r) ^ mode_r;
      eff_sub    = sign_a ^ sign_b_eff;
      shift_load = (exp_diff > SHIFT_CAP) ? SHIFT_CAP : exp_diff;
   end

   fp8_mag_swap u_mag_swap (
      .a_exp      (get_exp(a_r)),
      .a_frac     (get_frac(a_r)),
      .b_exp      (get_exp(b_r)),
      .b_frac     (get_frac(b_r)),
      .swap       (swap),
      .mag_equal  (mag_equal),
      .big_exp    (big_exp),
      .exp_diff   (exp_diff),
      .big_mant   (big_mant),
      .small_mant (small_mant)
   );

   // Main sequencer. All datapath registers live in this one block so the
   // per-state actions read top to bottom. NORM performs one shift per cycle
   // and leaves as soon as the value it writes is normalised, so a sum that
   // needs n left shifts spends exactly n cycles here (and one cycle when no
   // shift, or a single right shift, is needed). Result and flags are only
   // written on entry to DONE, which keeps them stable while the consumer
   // stalls; flags are dropped again on the release edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_r          <= '0;
         b_r          <= '0;
         mode_r       <= 1'b0;
         res_sign     <= 1'b0;
         sub_r        <= 1'b0;
         exp_r        <= '0;
         mant_big_r   <= '0;
         mant_small_r <= '0;
         shift_cnt    <= '0;
         sum_r        <= '0;
         result_r     <= ZERO_WORD;
         zero_r       <= 1'b0;
         ovf_r        <= 1'b0;
         unf_r        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r    <= op_a;
                  b_r    <= op_b;
                  mode_r <= mode;
                  state  <= SETUP;
               end
            end

            SETUP: begin
               res_sign     <= swap ? sign_b_eff : sign_a;
               sub_r        <= eff_sub;
               exp_r        <= big_exp;
               mant_big_r   <= big_mant;
               mant_small_r <= small_mant;
               if (eff_sub && mag_equal) begin
                  result_r <= ZERO_WORD;
                  zero_r   <= 1'b1;
                  state    <= DONE;
               end else begin
                  shift_cnt <= shift_load;
                  state     <= (shift_load != '0) ? SHIFT : ADD;
               end
            end

            SHIFT: begin
               mant_small_r <= mant_small_r >> 1;
               shift_cnt    <= shift_cnt - 1'b1;
               if (shift_cnt == EXP_W'(1)) begin
                  state <= ADD;
               end
            end

            ADD: begin
               if (sub_r) begin
                  sum_r <= {1'b0, mant_big_r} - {1'b0, mant_small_r};
               end else begin
                  sum_r <= {1'b0, mant_big_r} + {1'b0, mant_small_r};
               end
               state <= NORM;
            end

            NORM: begin
               if (sum_r[MANT_W]) begin
                  if (exp_r == EXP_MAX) begin
                     result_r <= {res_sign, SAT_MAG};
                     ovf_r    <= 1'b1;
                  end else begin
                     result_r <= {res_sign, exp_r + 1'b1, sum_r[MANT_W-1:1]};
                  end
                  state <= DONE;
               end else if (sum_r[MANT_W-1]) begin
                  result_r <= {res_sign, exp_r, sum_r[FRAC_W-1:0]};
                  state    <= DONE;
               end else if (exp_r == EXP_MIN) begin
                  result_r <= {res_sign, UNF_MAG};
                  unf_r    <= 1'b1;
                  state    <= DONE;
               end else begin
                  sum_r <= sum_r << 1;
                  exp_r <= exp_r - 1'b1;
                  if (sum_r[MANT_W-2]) begin
                     result_r <= {res_sign, exp_r - 1'b1, sum_r[FRAC_W-2:0], 1'b0};
                     state    <= DONE;
                  end
               end
            end

            DONE: begin
               if (out_ready) begin
                  zero_r <= 1'b0;
                  ovf_r  <= 1'b0;
                  unf_r  <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Handshake outputs are pure decodes of the state register, so nothing
   // on the input side can reach an output within the same cycle.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      result    = result_r;
      zero      = zero_r;
      ovf       = ovf_r;
      unf       = unf_r;
   end

endmodule

// File: tb/tb_fp8_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp8_addsub_seq
// Directed bench for the mini-float add/subtract sequencer. Each vector is
// launched through the input handshake, the edges until out_valid are
// counted, and the result, flags and latency are compared with values
// worked out by hand. Also covers reset state, consumer back-pressure and
// reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_fp8_addsub_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] op_a = 8'h00;
   logic [7:0] op_b = 8'h00;
   logic       mode = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] result;
   logic       zero;
   logic       ovf;
   logic       unf;

   int n_compared = 0;
   int n_mismatched = 0;

   fp8_addsub_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .ovf       (ovf),
      .unf       (unf)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one operand pair; returns just after the accept edge (edge 0).
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic m);
      @(negedge clk);
      op_a     = a;
      op_b     = b;
      mode     = m;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid is seen (bounded).
   task automatic waitDone(output int lat);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
      end
   endtask

   // Takes the result and checks the block is back in IDLE with flags clear.
   task automatic releaseResult(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, " in_ready after release"}, in_ready, 1'b1);
      checkOutput({tag, " out_valid after release"}, out_valid, 1'b0);
      checkOutput({tag, " flags after release"}, {zero, ovf, unf}, 3'b000);
   endtask

   // Full transaction: launch, wait, compare everything, release.
   task automatic runVector(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic m,
                            input logic [7:0] exp_res, input logic exp_zero,
                            input logic exp_ovf, input logic exp_unf,
                            input int exp_lat);
      int lat;
      applyStimulus(a, b, m);
      waitDone(lat);
      checkOutput({tag, " latency"}, lat, exp_lat);
      checkOutput({tag, " result"}, result, exp_res);
      checkOutput({tag, " zero"}, zero, exp_zero);
      checkOutput({tag, " ovf"}, ovf, exp_ovf);
      checkOutput({tag, " unf"}, unf, exp_unf);
      releaseResult(tag);
   endtask

   initial begin
      int lat;

      // Reset state
      #12;
      checkOutput("reset in_ready", in_ready, 1'b1);
      checkOutput("reset out_valid", out_valid, 1'b0);
      checkOutput("reset result", result, 8'h00);
      checkOutput("reset flags", {zero, ovf, unf}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;

      // 1.0 + 1.0 = 2.0: carry out, one right shift
      runVector("add_carry", 8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 3);
      // 1.0 - 0.75 = 0.25: one alignment shift, two left shifts
      runVector("sub_norm2", 8'h30, 8'h28, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 5);
      // 0.75 - 1.0 = -0.25: B is bigger, sign comes from effective B
      runVector("sub_swap", 8'h28, 8'h30, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 5);
      // Exact cancellation, both via mode and via opposite signs
      runVector("cancel_mode", 8'h35, 8'h35, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1);
      runVector("cancel_sign", 8'hB5, 8'h35, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1);
      // Exponent overflow saturates
      runVector("overflow", 8'h70, 8'h70, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 3);
      // Underflow at exponent 0 (not a cancellation)
      runVector("underflow", 8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3);
      // Exponent gap 6 clamps to 5 shifts, small operand flushes
      runVector("shift_cap", 8'h70, 8'h10, 1'b0, 8'h70, 1'b0, 1'b0, 1'b0, 8);
      // Truncated alignment: 1.9375 + 0.53125 -> 11111 + 01000 = 100111
      runVector("truncate", 8'h3F, 8'h21, 1'b0, 8'h43, 1'b0, 1'b0, 1'b0, 4);

      // Back-pressure: result held for 10 cycles while in_valid is driven
      applyStimulus(8'h30, 8'h30, 1'b0);
      waitDone(lat);
      checkOutput("hold latency", lat, 3);
      @(negedge clk);
      op_a     = 8'h70;
      op_b     = 8'h70;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput($sformatf("hold result c%0d", i), result, 8'h40);
         checkOutput($sformatf("hold out_valid c%0d", i), out_valid, 1'b1);
         checkOutput($sformatf("hold in_ready c%0d", i), in_ready, 1'b0);
         checkOutput($sformatf("hold flags c%0d", i), {zero, ovf, unf}, 3'b000);
      end
      in_valid = 1'b0;
      releaseResult("hold");

      // Reset during SHIFT aborts with no output
      applyStimulus(8'h70, 8'h10, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset in_ready", in_ready, 1'b1);
      checkOutput("midreset out_valid", out_valid, 1'b0);
      checkOutput("midreset result", result, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("postreset in_ready", in_ready, 1'b1);
      checkOutput("postreset out_valid", out_valid, 1'b0);

      // Normal operation resumes after the abort
      runVector("after_reset", 8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/fp8_addsub_seq.md
# fp8_addsub_seq

Multi-cycle sequencer for 8-bit mini-float add/subtract with valid/ready handshakes on both sides. Format is sign | 3-bit exponent | 4-bit fraction, always with an implied leading 1, bias 3; 0x00 encodes +2^-3, not zero. The block captures one operand pair, then runs four phases: swap, iterative alignment, add/sub, iterative normalisation. It holds the packed result until the consumer takes it. It sits between the lab operand source and the result display/check logic.

## Interface
- EXP_W, 3: exponent width; bias = 2^(EXP_W-1)-1.
- FRAC_W, 4: fraction width; mantissa width MANT_W = FRAC_W+1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE.
- op_a  in  8  operand A.
- op_b  in  8  operand B.
- mode  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result valid, high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  8  packed result.
- zero  out  1  exact cancellation; result = 0x00.
- ovf  out  1  exponent overflow; result saturated.
- unf  out  1  exponent underflow; result = {sign,7'b0}.

## Operation
- **States and transitions:**
  - IDLE → SETUP on in_valid (capture edge).
  - SETUP → SHIFT if the shift count is nonzero, else ADD. SETUP → DONE on cancellation.
  - SHIFT → ADD when the count reaches 0.
  - ADD → NORM.
  - NORM → DONE when normalised, overflowed or underflowed.
  - DONE → IDLE on out_ready.
- **Capture (IDLE):**
  - Register op_a, op_b and mode.
  - Effective sign of B is op_b[7]^mode.
  - Effective subtract when sign_a != effective sign_b.
- **SETUP:**
  - Order the operands by magnitude: exponent first, then fraction on a tie. The larger becomes "big"; swap if B is larger.
  - Result sign = sign of big.
  - If the subtract is effective and the magnitudes are equal: result 0x00, zero=1, go straight to DONE.
  - Load the shift count with min(exp_big - exp_small, 5).
- **SHIFT:**
  - Each cycle, shift the small mantissa right 1 bit (truncate) and decrement the count.
  - The cap of 5 flushes the small mantissa to 0.
- **ADD:**
  - 6-bit sum = {0,mant_big} ± {0,mant_small}.
  - The subtract result is never negative.
- **NORM (one action per cycle):**
  - If sum[5]: shift right 1, exp+1, go to DONE. If exp was 7, go to DONE with ovf=1 and result {sign,7'h7F}.
  - Else if sum[4]: go to DONE.
  - Else: shift left 1, exp-1, stay. If exp was 0, go to DONE with unf=1 and result {sign,7'h00}.
- **Rounding:** truncation throughout; no sticky bits.
- **Handshake:**
  - Inputs are ignored outside IDLE.
  - In DONE, result and flags are stable while out_valid=1 && out_ready=0.
  - Flags are cleared when leaving DONE.

## Timing
- **Reset values:** state IDLE, in_ready=1, out_valid=0, result=0x00, zero=ovf=unf=0. Reset mid-operation aborts the operation with no output.
- **Accept:** occurs on the edge where in_valid && in_ready (edge 0).
- **Latency:** out_valid rises after edge 2 + s + max(n,1), where s = SHIFT cycles and n = NORM shifts.
  - Cancellation: out_valid rises after edge 1.
- **Result release:** occurs on the edge with out_valid && out_ready. in_ready is high the following cycle.
- **Throughput:** no overlap between operations. A new accept is possible the cycle after release at the earliest.
- All outputs are registered or decoded from the state register. No combinational path from any input to any output.

## Structure
- **Package fp8_pkg:**
  - EXP_W, FRAC_W, BIAS and MANT_W.
  - State enum: IDLE, SETUP, SHIFT, ADD, NORM, DONE.
  - Field-extract functions (sign, exp, frac).
  - Saturation constants.
- **Sub-module fp8_mag_swap (combinational):** magnitude compare, swap, equality detect, exponent difference. Used in SETUP.
- **Top level:** FSM, shift counter and datapath registers.

## Test plan
- op_a=0x30, op_b=0x30, mode=0 → result 0x40, flags 0, out_valid after edge 3 (s=0, n=1).
- op_a=0x30, op_b=0x28, mode=1 → result 0x10, out_valid after edge 5 (s=1, n=2).
- op_a=0x35, op_b=0x35, mode=1 → result 0x00, zero=1, out_valid after edge 1. Repeat with op_a=0xB5, op_b=0x35, mode=0 → same response.
- op_a=0x70, op_b=0x70, mode=0 → result 0x7F, ovf=1. op_a=0x01, op_b=0x00, mode=1 → result 0x00, unf=1, zero=0.
- op_a=0x70, op_b=0x10, mode=0 (diff 6, capped at 5) → result 0x70, out_valid after edge 8.
- Hold out_ready=0 for 10 cycles → result and flags stable, in_ready=0, in_valid ignored. Assert rst_n=0 during SHIFT → next cycle IDLE, out_valid=0, in_ready=1, result=0x00.
